instr_fetch_queue: RTL

- Instruction fetch front end upstream of the pipeline's IF/ID register.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Accepts in-order responses, buffers {pc, instr} pairs in a FIFO, and presents the head to the pipeline with a stall input.
- On a taken branch/jump redirect, discards the FIFO and all in-flight responses, then restarts fetch at the target.

---
 rtl/instr_fetch_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential fetch over a valid/ready request channel,
// in-order response buffering, redirect flush. Optional response bypass: FETCH_BYPASS_EN.
`timescale 1ns/1ps
module instr_fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_out,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);
  localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUTSTANDING - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  logic [31:0]   tag_q  [MAX_OUTSTANDING];
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic   req_fire, resp_keep, bypass, fifo_push, fifo_pop, head_valid;
  logic [CW:0] inflight;
  entry_t resp_entry, head_entry;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    inflight   = {1'b0, count_q} + {1'b0, outst_q};
    // Gated by rst so the request channel is quiet while reset is held.
    imem_req_valid = rst && !redirect_valid && (outst_q < MAX_OUT_C) && (inflight < DEPTH_C);
    imem_req_addr  = fetch_pc_q;
    req_fire   = imem_req_valid && imem_req_ready;
    resp_keep  = imem_resp_valid && (drop_q == '0) && !redirect_valid;
    resp_entry = '{pc: tag_q[tag_rd_q], instr: imem_resp_data};
    head_entry = fifo_q[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
    bypass     = resp_keep && (count_q == '0) && !stall;
`else
    bypass     = 1'b0;
`endif
    fifo_push  = resp_keep && !bypass;
    head_valid = (count_q != '0) && !redirect_valid;
    fifo_pop   = head_valid && !stall;
    instr_valid = head_valid || bypass;
    instr_pc    = '0;
    instr_out   = NOP;
    if (bypass) begin
      instr_pc  = resp_entry.pc;
      instr_out = resp_entry.instr;
    end else if (head_valid) begin
      instr_pc  = head_entry.pc;
      instr_out = head_entry.instr;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;

    if (req_fire) tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TW'(1);
    if (imem_resp_valid) tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TW'(1);

    case ({req_fire, imem_resp_valid})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (redirect_valid) begin
      // No request fires during a redirect, so everything still in flight after this
      // edge was accepted for the old path and must be thrown away.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = outst_q - CW'(imem_resp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (fifo_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // NOTE: storage arrays are not reset; their contents are only observed through count/pointers.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_q[wr_ptr_q] <= resp_entry;
    if (req_fire)  tag_q[tag_wr_q]  <= fetch_pc_q;
  end

endmodule
